alu_uart_sequencer: RTL

//  Sequences the shared combinational ALU from a byte stream delivered by the UART receiver.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_timeout.sv | 30 +++
 rtl/alu_uart_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and sequencer state encoding.
// Imported by the sequencer, its timeout sub-module and the bench.
package alu_pkg;

  localparam int NB_BITS_DEF = 8;
  localparam int NB_OPE_DEF  = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_WAIT_A  = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_B  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_OP = 3'd2;
  localparam logic [ST_W-1:0] ST_EXEC    = 3'd3;
  localparam logic [ST_W-1:0] ST_SEND    = 3'd4;
  localparam logic [ST_W-1:0] ST_WAIT_TX = 3'd5;

endpackage

// File: rtl/alu_seq_timeout.sv
// Inter-byte idle counter: clears on every received byte, counts while enabled,
// and flags expiry combinationally once the count reaches TIMEOUT_CYCLES-1.
module alu_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clear || !i_count_en || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_expire = i_count_en && !i_clear && (count == LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, opcode from the UART byte stream onto registered ALU inputs, captures the
// result and hands its low byte to the UART transmitter. Optional idle abort: ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int NB_BITS        = NB_BITS_DEF,
  parameter int NB_OPE         = NB_OPE_DEF,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BITS-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_BITS:0]   i_alu_result,
  output logic [NB_BITS-1:0] o_alu_a,
  output logic [NB_BITS-1:0] o_alu_b,
  output logic [NB_OPE-1:0]  o_alu_op,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_carry,
  output logic               o_busy,
  output logic               o_drop
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $fatal(1, "TIMEOUT_CYCLES must be at least 2");
  end

  logic [ST_W-1:0] state;
  logic            timeout_expire;
  logic            collecting;

  assign collecting = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
  assign o_busy     = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);

`ifdef ALU_SEQ_TIMEOUT_EN
  alu_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (i_rx_done),
    .i_count_en (collecting),
    .o_expire   (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_carry    <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_drop     <= i_rx_done && o_busy;
      case (state)
        ST_WAIT_A: begin
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            state   <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_done) begin
            o_alu_b <= i_rx_data;
            state   <= ST_WAIT_OP;
          end else if (timeout_expire) begin
            state <= ST_WAIT_A;
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[NB_OPE-1:0];
            state    <= ST_EXEC;
          end else if (timeout_expire) begin
            state <= ST_WAIT_A;
          end
        end
        // ALU inputs settled one cycle ago; start pulse is registered so it lands in SEND.
        ST_EXEC: begin
          o_tx_data  <= i_alu_result[NB_BITS-1:0];
          o_carry    <= i_alu_result[NB_BITS];
          o_tx_start <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            state <= ST_WAIT_A;
          end
        end
        default: begin
          state <= ST_WAIT_A;
        end
      endcase
    end
  end

endmodule
